// File: rtl/irq_arbiter.sv
// Interrupt arbiter: synchronises and edge-detects irq lines, keeps per-source pending bits,
// grants one source at a time and pulses fetch. Define IRQ_ARBITER_RR_EN for round-robin arbitration.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no service active; moves to ST_WAIT once anything is pending
// ST_WAIT    | pending work, waiting for mem_busy=0 and flush=0 to grant
// ST_ISSUE   | interrupt pulse cycle to fetch; handler considered started
// ST_SERVICE | handler running; rti/rsi returns to ST_IDLE

module irq_arbiter #(
   parameter int NUM_SRC     = 2,
   parameter int SYNC_STAGES = 2,
   parameter int IDW         = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_SRC-1:0]     irq_in,
   input  logic [32*NUM_SRC-1:0]  src_data,
   input  logic                   mem_busy,
   input  logic                   flush,
   input  logic                   rti,
   input  logic                   rsi,
   output logic                   interrupt,
   output logic                   in_service,
   output logic [IDW-1:0]         active_id,
   output logic [31:0]            rdi_data,
   output logic [NUM_SRC-1:0]     pending,
   output logic [7:0]             drop_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_ISSUE   = 2'd2,
      ST_SERVICE = 2'd3
   } state_t;

   state_t               r_state;
   logic [NUM_SRC-1:0]   r_sync [SYNC_STAGES];
   logic [NUM_SRC-1:0]   r_prev;
   logic [NUM_SRC-1:0]   r_pending;
   logic [7:0]           r_drop_cnt;
   logic                 r_interrupt;
   logic                 r_in_service;
   logic [IDW-1:0]       r_active_id;
   logic [31:0]          r_rdi_data;

   logic [NUM_SRC-1:0]   w_synced;
   logic [NUM_SRC-1:0]   w_edge;
   logic [NUM_SRC-1:0]   w_clr;
   logic [NUM_SRC-1:0]   w_drop;
   logic [NUM_SRC-1:0]   w_pending_nxt;
   logic [15:0]          w_drop_sum;
   logic [7:0]           w_drop_nxt;
   logic [IDW-1:0]       w_winner;
   logic [31:0]          w_win_data;
   logic                 w_found;
   logic                 w_grant;
   logic                 w_ret;

   // ------------------------------------------------------------------
   // Synchroniser chain and rising-edge detect
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            r_sync[k] <= '0;
         end
         r_prev <= '0;
      end else begin
         r_sync[0] <= irq_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
         end
         r_prev <= w_synced;
      end
   end

   assign w_synced = r_sync[SYNC_STAGES-1];
   assign w_edge   = w_synced & ~r_prev;

   // ------------------------------------------------------------------
   // Winner selection
   // ------------------------------------------------------------------
`ifdef IRQ_ARBITER_RR_EN
   logic [IDW-1:0] r_last_grant;

   // Search starts one past the last granted source and wraps.
   always_comb begin
      w_winner = '0;
      w_found  = 1'b0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && r_pending[i] &&
                (((int'(r_last_grant) + k) % NUM_SRC) == i)) begin
               w_found  = 1'b1;
               w_winner = IDW'(i);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= '0;
      end else if (w_grant) begin
         r_last_grant <= w_winner;
      end
   end
`else
   always_comb begin
      w_winner = '0;
      w_found  = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_found  = 1'b1;
            w_winner = IDW'(i);
         end
      end
   end
`endif

   always_comb begin
      w_win_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_winner == IDW'(i)) begin
            w_win_data = src_data[32*i +: 32];
         end
      end
   end

   assign w_grant = (r_state == ST_WAIT) && !mem_busy && !flush && w_found;
   assign w_ret   = rti | rsi;

   // ------------------------------------------------------------------
   // Pending bits and lost-edge counter
   // ------------------------------------------------------------------
   // A fresh edge on the winner in the grant cycle overrides the clear.
   always_comb begin
      w_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_clr[i] = w_grant && (w_winner == IDW'(i));
      end
   end

   assign w_drop        = w_edge & r_pending & ~w_clr;
   assign w_pending_nxt = (r_pending & ~w_clr) | w_edge;

   always_comb begin
      w_drop_sum = {8'd0, r_drop_cnt};
      for (int i = 0; i < NUM_SRC; i++) begin
         w_drop_sum = w_drop_sum + 16'(w_drop[i]);
      end
      w_drop_nxt = (w_drop_sum > 16'd255) ? 8'hFF : w_drop_sum[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending  <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_pending  <= w_pending_nxt;
         r_drop_cnt <= w_drop_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Control FSM with registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_interrupt  <= 1'b0;
         r_in_service <= 1'b0;
         r_active_id  <= '0;
         r_rdi_data   <= '0;
      end else begin
         r_interrupt <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|r_pending) begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (w_grant) begin
                  r_active_id  <= w_winner;
                  r_rdi_data   <= w_win_data;
                  r_interrupt  <= 1'b1;
                  r_in_service <= 1'b1;
                  r_state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (w_ret) begin
                  r_in_service <= 1'b0;
                  r_state      <= ST_IDLE;
               end else begin
                  r_state <= ST_SERVICE;
               end
            end
            ST_SERVICE: begin
               if (w_ret) begin
                  r_in_service <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_in_service <= 1'b0;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

   assign interrupt  = r_interrupt;
   assign in_service = r_in_service;
   assign active_id  = r_active_id;
   assign rdi_data   = r_rdi_data;
   assign pending    = r_pending;
   assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios plus randomized traffic checked each cycle
// against a behavioural model; honours IRQ_ARBITER_RR_EN like the design.

module tb_irq_arbiter;

   localparam int N    = 2;
   localparam int SYNC = 2;
   localparam int IDW  = 1;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     irq_in;
   logic [32*N-1:0]  src_data;
   logic             mem_busy;
   logic             flush;
   logic             rti;
   logic             rsi;
   logic             interrupt;
   logic             in_service;
   logic [IDW-1:0]   active_id;
   logic [31:0]      rdi_data;
   logic [N-1:0]     pending;
   logic [7:0]       drop_cnt;

   irq_arbiter #(.NUM_SRC(N), .SYNC_STAGES(SYNC), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .src_data(src_data),
      .mem_busy(mem_busy), .flush(flush), .rti(rti), .rsi(rsi),
      .interrupt(interrupt), .in_service(in_service), .active_id(active_id),
      .rdi_data(rdi_data), .pending(pending), .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   // Behavioural model: raw-sample history, pending set, service phase.
   logic [N-1:0] hist[$];
   logic [N-1:0] m_pend;
   int           m_drop;
   int           m_phase;   // 0 idle, 1 waiting, 2 pulse cycle, 3 handler running
   int           m_id;
   logic [31:0]  m_rdi;
   int           m_last;

   task automatic model_reset();
      hist.delete();
      for (int j = 0; j <= SYNC; j++) hist.push_back('0);
      m_pend  = '0;
      m_drop  = 0;
      m_phase = 0;
      m_id    = 0;
      m_rdi   = '0;
      m_last  = 0;
   endtask

   function automatic int pick();
`ifdef IRQ_ARBITER_RR_EN
      for (int k = 1; k <= N; k++) begin
         if (m_pend[(m_last + k) % N]) return (m_last + k) % N;
      end
`else
      for (int i = 0; i < N; i++) begin
         if (m_pend[i]) return i;
      end
`endif
      return 0;
   endfunction

   task automatic model_step(input logic [N-1:0] raw, input logic busy, input logic fl,
                             input logic ri, input logic rs, input logic [32*N-1:0] data);
      logic [N-1:0] e;
      logic [N-1:0] pend_before;
      int win;
      e = hist[SYNC-1] & ~hist[SYNC];
      pend_before = m_pend;
      win = -1;
      if (m_phase == 1 && !busy && !fl && pend_before != 0) begin
         win    = pick();
         m_id   = win;
         m_rdi  = data[32*win +: 32];
         m_last = win;
      end
      for (int i = 0; i < N; i++) begin
         if (e[i]) begin
            if (pend_before[i] && i != win) m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
            m_pend[i] = 1'b1;
         end else if (i == win) begin
            m_pend[i] = 1'b0;
         end
      end
      case (m_phase)
         0: if (pend_before != 0) m_phase = 1;
         1: if (win >= 0) m_phase = 2;
         2: m_phase = (ri || rs) ? 0 : 3;
         default: if (ri || rs) m_phase = 0;
      endcase
      hist.push_front(raw);
      void'(hist.pop_back());
   endtask

   task automatic check_all();
      chk("interrupt", 32'(interrupt), 32'(m_phase == 2));
      chk("in_service", 32'(in_service), 32'(m_phase == 2 || m_phase == 3));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("active_id", 32'(active_id), 32'(m_id));
      chk("rdi_data", rdi_data, m_rdi);
   endtask

   // Drive one cycle (called at a negedge), advance model, check at next negedge.
   task automatic cycle(input logic [N-1:0] raw, input logic busy, input logic fl,
                        input logic ri, input logic rs, input logic [32*N-1:0] data);
      irq_in   = raw;
      mem_busy = busy;
      flush    = fl;
      rti      = ri;
      rsi      = rs;
      src_data = data;
      model_step(raw, busy, fl, ri, rs, data);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      irq_in = '0; mem_busy = 1'b0; flush = 1'b0; rti = 1'b0; rsi = 1'b0; src_data = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check_all();
   endtask

   // Reset asserted between clock edges; outputs must clear without a clock.
   task automatic async_reset();
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_interrupt", 32'(interrupt), 32'd0);
      chk("arst_in_service", 32'(in_service), 32'd0);
      chk("arst_pending", 32'(pending), 32'd0);
      chk("arst_drop_cnt", 32'(drop_cnt), 32'd0);
      irq_in = '0; mem_busy = 1'b0; flush = 1'b0; rti = 1'b0; rsi = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_all();
   endtask

   task automatic wait_irq(input logic [N-1:0] raw, input int limit, output int n);
      n = 0;
      for (int c = 1; c <= limit; c++) begin
         cycle(raw, 1'b0, 1'b0, 1'b0, 1'b0, {32'hDEADBEEF, 32'h0000CAFE});
         if (interrupt) begin
            n = c;
            break;
         end
      end
   endtask

   task automatic pulse0(input int count);
      for (int p = 0; p < count; p++) begin
         repeat (2) cycle(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, '0);
         repeat (2) cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      end
   endtask

   task automatic hold_test(input logic use_flush, input string tag);
      repeat (3) cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      repeat (15) cycle(2'b01, !use_flush, use_flush, 1'b0, 1'b0, '0);
      chk({tag, "_no_irq"}, 32'(interrupt), 32'd0);
      chk({tag, "_pending"}, 32'(pending), 32'd1);
      cycle(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, {32'h0, 32'h00001234});
      chk({tag, "_irq_after_release"}, 32'(interrupt), 32'd1);
      chk({tag, "_rdi"}, rdi_data, 32'h00001234);
      cycle(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      chk({tag, "_ret"}, 32'(in_service), 32'd0);
   endtask

   initial begin
      int n;
      logic [N-1:0] r;
      logic [31:0] first_exp;

      do_reset();
      chk("reset_interrupt", 32'(interrupt), 32'd0);
      chk("reset_pending", 32'(pending), 32'd0);

      // Single edge on source 1, idle pipeline.
      wait_irq(2'b10, 20, n);
      chk("latency_src1", 32'(n), 32'd5);
      chk("id_src1", 32'(active_id), 32'd1);
      chk("rdi_src1", rdi_data, 32'hDEADBEEF);
      cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      chk("pulse_one_cycle", 32'(interrupt), 32'd0);
      chk("in_service_held", 32'(in_service), 32'd1);
      repeat (3) cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      cycle(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      chk("rti_ends_service", 32'(in_service), 32'd0);
      chk("id_holds", 32'(active_id), 32'd1);

      hold_test(1'b0, "busy_hold");
      hold_test(1'b1, "flush_hold");

      // Simultaneous edges on both sources from a fresh reset.
      do_reset();
`ifdef IRQ_ARBITER_RR_EN
      first_exp = 32'd1;
`else
      first_exp = 32'd0;
`endif
      wait_irq(2'b11, 20, n);
      chk("both_first_latency", 32'(n), 32'd5);
      chk("both_first_id", 32'(active_id), first_exp);
      n = 0;
      for (int c = 1; c <= 12; c++) begin
         cycle(2'b11, 1'b0, 1'b0, (c == 1), 1'b0, '0);
         if (interrupt) begin
            n = c;
            break;
         end
      end
      chk("b2b_gap", 32'(n), 32'd3);
      chk("both_second_id", 32'(active_id), 32'd1 - first_exp);

      // Lost edges while servicing source 1.
      do_reset();
      wait_irq(2'b10, 20, n);
      chk("drop_setup_irq", 32'(n), 32'd5);
      pulse0(3);
      repeat (4) cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      chk("drop_pending0", 32'(pending[0]), 32'd1);
      chk("drop_cnt_2", 32'(drop_cnt), 32'd2);
      pulse0(300);
      repeat (4) cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      chk("drop_cnt_sat", 32'(drop_cnt), 32'd255);
      chk("drop_still_serv", 32'(in_service), 32'd1);

      // Async reset mid-service, then a stale rti.
      async_reset();
      cycle(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      chk("stale_rti_ignored", 32'(in_service), 32'd0);
      repeat (3) cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      chk("idle_after_rst", 32'(interrupt), 32'd0);

      // Randomized traffic against the model.
      r = '0;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
         end
         cycle(r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
               {$urandom, $urandom});
         if ($urandom_range(0, 699) == 0) begin
            async_reset();
            r = '0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Interrupt controller for the 5-stage RISC-V core.
- Synchronises and edge-detects NUM_SRC external interrupt lines and holds a pending bit per source.
- Picks one winner and issues a single-cycle interrupt pulse to fetch, but only when no memory op is in flight and no flush is active.
- Latches the winner's source data for RDI and blocks further issue until RTI or RSI retires the service.

Parameters:
- NUM_SRC, 2, number of interrupt sources; index 0 = key, 1 = ethernet.
- SYNC_STAGES, 2, synchroniser flops per irq_in line (minimum 2).
- IDW, 1, width of active_id; must satisfy 2**IDW >= NUM_SRC.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- irq_in  in  NUM_SRC  raw interrupt lines, asynchronous, level.
- src_data  in  32*NUM_SRC  per-source payload; slice i = bits [32*i+31:32*i].
- mem_busy  in  1  OR of memory-read enables in IF/ID/EX/MEM; no issue while high.
- flush  in  1  pipeline flush (branch/rti/rsi); no issue while high.
- rti  in  1  return-from-interrupt decoded, one-cycle pulse.
- rsi  in  1  return-from-service decoded, one-cycle pulse.
- interrupt  out  1  one-cycle pulse to fetch.
- in_service  out  1  high while a handler runs.
- active_id  out  IDW  index of the granted source.
- rdi_data  out  32  payload captured at grant, returned by RDI.
- pending  out  NUM_SRC  pending bits.
- drop_cnt  out  8  saturating count of lost edges.

Behaviour:
- Reset (async, rst_n=0): all synchronisers, edge history, pending, drop_cnt, active_id and rdi_data go to 0. interrupt=0, in_service=0, state=IDLE. Asserting reset mid-service aborts the service immediately.
- Sync and edge detection: irq_in[i] passes through SYNC_STAGES flops. A 0->1 transition on the synchronised line sets pending[i] on the next edge. Level-high without a new edge does not re-set the bit.
- Lost edge: a new edge while pending[i] is already 1 increments drop_cnt, saturating at 255. Several sources dropping in the same cycle add one per source.
- Winner: default is fixed priority, lowest set index wins.
- States: IDLE, WAIT, ISSUE, SERVICE.
- IDLE: if pending != 0, go to WAIT next cycle.
- WAIT: when mem_busy=0 and flush=0, grant.
  - Latch active_id = winner and rdi_data = src_data slice of the winner.
  - Clear pending[winner]; a new edge on the winner in the same cycle wins, so the bit stays 1 and nothing is dropped.
  - Go to ISSUE.
  - If mem_busy or flush is high, stay in WAIT; the winner is re-evaluated every cycle.
- ISSUE: interrupt=1 for exactly this cycle, in_service=1, then go to SERVICE.
- SERVICE: in_service=1. On rti or rsi (either or both) go to IDLE next cycle with in_service=0. active_id and rdi_data hold their values until the next grant.
- rti/rsi outside SERVICE/ISSUE are ignored. rti in the ISSUE cycle is honoured as the end of service.
- Latency: pending set at cycle N gives interrupt high at N+2 when the pipeline is idle. Raw edge to interrupt is SYNC_STAGES+3 cycles.
- Back-to-back: after return, the next pending source pulses no earlier than 3 cycles after the rti cycle.
- interrupt, in_service, active_id and rdi_data are all registered outputs.

Optional Feature:
- Macro IRQ_ARBITER_RR_EN.
- Defined: round-robin arbitration. A last-grant pointer (reset 0) is updated at each grant, and search starts at last_grant+1, wrapping modulo NUM_SRC.
- Undefined: fixed priority, lowest index wins, and no pointer is built.

Test Plan:
- Edge on irq_in[1] with mem_busy=0 and src_data[63:32]=0xDEADBEEF -> interrupt pulses 1 cycle at SYNC_STAGES+3 = cycle 5. Then active_id=1, rdi_data=0xDEADBEEF, in_service=1 until an rti pulse; in_service=0 the cycle after.
- Hold mem_busy=1 for 10 cycles with pending[0]=1 -> no interrupt, state WAIT. interrupt pulses 1 cycle after mem_busy falls; flush=1 gives the same hold.
- Edges on both sources in the same cycle, RR undefined -> source 0 serviced first; after rti, source 1 issues 3 cycles later.
- Same as above with IRQ_ARBITER_RR_EN -> first grant source 1 (pointer reset 0), second grant source 0. Repeating the test alternates grants.
- Three edges on irq_in[0] while in SERVICE -> pending[0]=1, drop_cnt=2; 300 such drops -> drop_cnt=255.
- rst_n=0 asserted in SERVICE, asynchronously between clock edges -> in_service, interrupt, pending and drop_cnt all 0 immediately. State is IDLE after release, and a stale rti is ignored.
